// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM state and
// access-op encodings plus a constant log2 for index widths.
package data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x DW RAM with synchronous write and registered read.
// Contents are never reset; only the read register reflects accesses.
module dmem_ram
   import data_mem_arbiter_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int DW    = 16,
   parameter int IW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [IW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter serialising NCORES core data-memory requests onto one
// single-port RAM, with a preload port usable while the FSM is idle.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | accept preload write, or pick next requester round-robin
// ST_ACCESS | commit latched write to RAM / read data arrives from RAM
// ST_RESP   | pulse MEMRDY for granted core, advance rr_ptr
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int NCORES = 4,
   parameter int DW     = 16,
   parameter int AW     = 16,
   parameter int DEPTH  = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCORES-1:0]    MEMREAD,
   input  logic [NCORES-1:0]    MEMWR,
   input  logic [NCORES*AW-1:0] DMADDR,
   input  logic [NCORES*DW-1:0] DOUT,
   output logic [NCORES*DW-1:0] DIN,
   output logic [NCORES-1:0]    MEMRDY,
   input  logic                 INITWR,
   input  logic [AW-1:0]        INITADDR,
   input  logic [DW-1:0]        INITDATA,
   output logic                 BUSY
);

   localparam int IW = clog2(DEPTH);
   localparam int GW = (NCORES > 1) ? clog2(NCORES) : 1;

   state_t               state_q, state_d;
   logic [GW-1:0]        rr_ptr_q;
   logic [GW-1:0]        grant_q;
   op_t                  op_q;
   logic [IW-1:0]        addr_q;
   logic [DW-1:0]        wdata_q;
   logic [NCORES*DW-1:0] din_q;

   logic [NCORES-1:0]    req;
   logic                 pick_valid;
   logic [GW-1:0]        pick;
   logic                 grant_fire;

   logic                 ram_we;
   logic                 ram_re;
   logic [IW-1:0]        ram_addr;
   logic [DW-1:0]        ram_wdata;
   logic [DW-1:0]        ram_rdata;

   // Upper address bits only alias onto the RAM index and are ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{DMADDR, INITADDR};

   // First requester at or after ptr, wrapping; MSB flags a hit.
   function automatic logic [GW:0] rr_pick(input logic [NCORES-1:0] r,
                                           input logic [GW-1:0]     ptr);
      logic [GW:0] result;
      int          idx;
      result = '0;
      for (int k = NCORES - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NCORES;
         if (r[idx]) begin
            result = {1'b1, GW'(idx)};
         end
      end
      return result;
   endfunction

   assign req                = MEMREAD | MEMWR;
   assign {pick_valid, pick} = rr_pick(req, rr_ptr_q);
   assign grant_fire         = (state_q == ST_IDLE) && !INITWR && pick_valid;

   // Reads are issued on the grant edge so the data is ready to load into
   // DIN on the ACCESS->RESP edge; writes wait for ACCESS using latched data.
   always_comb begin
      state_d   = state_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (INITWR) begin
               ram_we    = !rst;
               ram_addr  = INITADDR[IW-1:0];
               ram_wdata = INITDATA;
            end else if (pick_valid) begin
               state_d  = ST_ACCESS;
               ram_addr = DMADDR[int'(pick)*AW +: IW];
               ram_re   = !MEMWR[pick] && !rst;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            ram_we  = (op_q == OP_WR) && !rst;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         op_q     <= OP_RD;
         addr_q   <= '0;
         wdata_q  <= '0;
         din_q    <= '0;
      end else begin
         state_q <= state_d;
         if (grant_fire) begin
            grant_q <= pick;
            op_q    <= MEMWR[pick] ? OP_WR : OP_RD;
            addr_q  <= DMADDR[int'(pick)*AW +: IW];
            wdata_q <= DOUT[int'(pick)*DW +: DW];
         end
         if (state_q == ST_ACCESS && op_q == OP_RD) begin
            din_q[int'(grant_q)*DW +: DW] <= ram_rdata;
         end
         if (state_q == ST_RESP) begin
            rr_ptr_q <= (grant_q == GW'(NCORES - 1)) ? '0 : grant_q + 1'b1;
         end
      end
   end

   always_comb begin
      MEMRDY = '0;
      if (state_q == ST_RESP) begin
         MEMRDY[grant_q] = 1'b1;
      end
   end

   assign BUSY = (state_q != ST_IDLE);
   assign DIN  = din_q;

   dmem_ram #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .IW    (IW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: expected completions are queued as
// requests are driven and checked as MEMRDY pulses arrive.
module tb_data_mem_arbiter;

   localparam int NC    = 4;
   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic [NC-1:0]     MEMREAD;
   logic [NC-1:0]     MEMWR;
   logic [NC*AW-1:0]  DMADDR;
   logic [NC*DW-1:0]  DOUT;
   logic [NC*DW-1:0]  DIN;
   logic [NC-1:0]     MEMRDY;
   logic              INITWR;
   logic [AW-1:0]     INITADDR;
   logic [DW-1:0]     INITDATA;
   logic              BUSY;

   data_mem_arbiter #(
      .NCORES (NC),
      .DW     (DW),
      .AW     (AW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .MEMREAD  (MEMREAD),
      .MEMWR    (MEMWR),
      .DMADDR   (DMADDR),
      .DOUT     (DOUT),
      .DIN      (DIN),
      .MEMRDY   (MEMRDY),
      .INITWR   (INITWR),
      .INITADDR (INITADDR),
      .INITDATA (INITDATA),
      .BUSY     (BUSY)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int            core;
      bit            rd;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      int core;
      int cyc;
   } rdy_t;

   exp_t          sb[$];
   rdy_t          rdy_log[$];
   logic [DW-1:0] ram_model [DEPTH];
   logic [DW-1:0] din_model [NC];
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic issue(input int c, input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      DMADDR[c*AW +: AW] = a;
      DOUT[c*DW +: DW]   = d;
      MEMREAD[c]         = rd;
      MEMWR[c]           = wr;
   endtask

   // Drive a request and queue its completion; calls are made in service order.
   task automatic request(input int c, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      issue(c, rd, wr, a, d);
      e.core = c;
      if (wr) begin
         ram_model[a[7:0]] = d;
         e.rd   = 1'b0;
         e.data = d;
      end else begin
         e.rd   = 1'b1;
         e.data = ram_model[a[7:0]];
      end
      sb.push_back(e);
   endtask

   task automatic do_init(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      INITWR   = 1'b1;
      INITADDR = a;
      INITDATA = d;
      @(negedge clk);
      INITWR = 1'b0;
      ram_model[a[7:0]] = d;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      MEMREAD = '0;
      MEMWR   = '0;
      INITWR  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NC; i++) din_model[i] = '0;
   endtask

   // Scoreboard consumer: runs until the queue is empty and the FSM idles.
   task automatic drain(input int budget);
      exp_t          e;
      logic [NC-1:0] exp_rdy;
      rdy_t          r;
      int            n;
      int            act;
      n = 0;
      while ((sb.size() != 0 || BUSY === 1'b1) && n < budget) begin
         @(negedge clk);
         n++;
         if (MEMRDY !== '0) begin
            act = -1;
            for (int i = NC - 1; i >= 0; i--) if (MEMRDY[i] === 1'b1) act = i;
            r.core = act;
            r.cyc  = cyc;
            rdy_log.push_back(r);
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_rdy: MEMRDY=%b, required no pulse", MEMRDY);
            end else begin
               e = sb.pop_front();
               exp_rdy = '0;
               exp_rdy[e.core] = 1'b1;
               if (MEMRDY !== exp_rdy) begin
                  n_fail++;
                  $display("FAIL rdy_core: MEMRDY=%b, required %b", MEMRDY, exp_rdy);
               end
               n_checks++;
               if (BUSY !== 1'b1) begin
                  n_fail++;
                  $display("FAIL busy_at_rdy: BUSY=%b, required 1", BUSY);
               end
               if (e.rd) din_model[e.core] = e.data;
               for (int i = 0; i < NC; i++) begin
                  n_checks++;
                  if (DIN[i*DW +: DW] !== din_model[i]) begin
                     n_fail++;
                     $display("FAIL din%0d: DIN=%h, required %h (core %0d done)",
                              i, DIN[i*DW +: DW], din_model[i], e.core);
                  end
               end
               MEMREAD[e.core] = 1'b0;
               MEMWR[e.core]   = 1'b0;
            end
         end
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d completions outstanding, required 0", sb.size());
         sb.delete();
         MEMREAD = '0;
         MEMWR   = '0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (MEMRDY !== '0) begin
         n_fail++;
         $display("FAIL reset_memrdy: MEMRDY=%b, required 0", MEMRDY);
      end
      n_checks++;
      if (BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: BUSY=%b, required 0", BUSY);
      end
      n_checks++;
      if (DIN !== '0) begin
         n_fail++;
         $display("FAIL reset_din: DIN=%h, required 0", DIN);
      end
   endtask

   task automatic test_preload_read();
      int t0;
      do_init(16'h0010, 16'hBEEF);
      @(negedge clk);
      rdy_log.delete();
      t0 = cyc;
      request(0, 1'b1, 1'b0, 16'h0010, 16'h0);
      @(negedge clk);
      n_checks++;
      if (BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_after_grant: BUSY=%b, required 1", BUSY);
      end
      drain(40);
      n_checks++;
      if (rdy_log.size() != 1 || rdy_log[0].cyc != t0 + 2) begin
         n_fail++;
         $display("FAIL read_latency: pulses=%0d at cycle %0d, required 1 at %0d",
                  rdy_log.size(), (rdy_log.size() > 0) ? rdy_log[0].cyc : -1, t0 + 2);
      end
   endtask

   task automatic test_write_then_read();
      request(2, 1'b0, 1'b1, 16'h0020, 16'h1234);
      drain(40);
      request(2, 1'b1, 1'b0, 16'h0020, 16'h0);
      drain(40);
   endtask

   task automatic test_read_write_both();
      request(1, 1'b1, 1'b1, 16'h0060, 16'h4321);
      drain(40);
      request(1, 1'b1, 1'b0, 16'h0060, 16'h0);
      drain(40);
   endtask

   task automatic test_round_robin();
      request(2, 1'b1, 1'b0, 16'h0010, 16'h0);
      drain(40);
      rdy_log.delete();
      request(3, 1'b1, 1'b0, 16'h0060, 16'h0);
      request(1, 1'b1, 1'b0, 16'h0020, 16'h0);
      drain(40);
      n_checks++;
      if (rdy_log.size() != 2 || rdy_log[0].core != 3 || rdy_log[1].core != 1) begin
         n_fail++;
         $display("FAIL rr_order: first=%0d second=%0d, required 3 then 1",
                  (rdy_log.size() > 0) ? rdy_log[0].core : -1,
                  (rdy_log.size() > 1) ? rdy_log[1].core : -1);
      end
   endtask

   task automatic test_init_wrap();
      do_init(16'hFF40, 16'h7777);
      request(2, 1'b1, 1'b0, 16'h0040, 16'h0);
      drain(40);
   endtask

   task automatic test_init_while_busy();
      do_init(16'h0050, 16'h0101);
      request(0, 1'b1, 1'b0, 16'h0050, 16'h0);
      @(negedge clk);
      INITWR   = 1'b1;
      INITADDR = 16'h0050;
      INITDATA = 16'hDEAD;
      @(posedge clk);
      #1;
      INITWR = 1'b0;
      drain(40);
      request(3, 1'b1, 1'b0, 16'h0050, 16'h0);
      drain(40);
   endtask

   task automatic test_all_cores();
      do_reset();
      rdy_log.delete();
      request(0, 1'b1, 1'b0, 16'h0010, 16'h0);
      request(1, 1'b0, 1'b1, 16'h0070, 16'h1111);
      request(2, 1'b1, 1'b0, 16'h0020, 16'h0);
      request(3, 1'b0, 1'b1, 16'h0071, 16'h2222);
      drain(60);
      n_checks++;
      if (rdy_log.size() != 4) begin
         n_fail++;
         $display("FAIL all_count: pulses=%0d, required 4", rdy_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdy_log[i].core != i) begin
               n_fail++;
               $display("FAIL all_order%0d: core=%0d, required %0d", i, rdy_log[i].core, i);
            end
         end
         for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (rdy_log[i].cyc - rdy_log[i-1].cyc != 3) begin
               n_fail++;
               $display("FAIL all_spacing%0d: gap=%0d, required 3", i,
                        rdy_log[i].cyc - rdy_log[i-1].cyc);
            end
         end
      end
      request(0, 1'b1, 1'b0, 16'h0071, 16'h0);
      drain(40);
   endtask

   task automatic test_addr_wrap();
      request(1, 1'b0, 1'b1, 16'h0105, 16'h00AA);
      drain(40);
      request(0, 1'b1, 1'b0, 16'h0005, 16'h0);
      drain(40);
   endtask

   task automatic test_reset_abort();
      int pulses;
      do_init(16'h0030, 16'h0000);
      @(negedge clk);
      issue(3, 1'b0, 1'b1, 16'h0030, 16'h5555);
      @(negedge clk);
      n_checks++;
      if (BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_in_access: BUSY=%b, required 1", BUSY);
      end
      rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      MEMWR[3] = 1'b0;
      for (int i = 0; i < NC; i++) din_model[i] = '0;
      n_checks++;
      if (BUSY !== 1'b0 || MEMRDY !== '0) begin
         n_fail++;
         $display("FAIL abort_state: BUSY=%b MEMRDY=%b, required 0 and 0", BUSY, MEMRDY);
      end
      n_checks++;
      if (DIN !== '0) begin
         n_fail++;
         $display("FAIL abort_din: DIN=%h, required 0", DIN);
      end
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (MEMRDY !== '0) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL abort_no_rdy: pulses=%0d, required 0", pulses);
      end
      rdy_log.delete();
      request(0, 1'b1, 1'b0, 16'h0030, 16'h0);
      request(1, 1'b1, 1'b0, 16'h0030, 16'h0);
      drain(40);
      n_checks++;
      if (rdy_log.size() != 2 || rdy_log[0].core != 0 || rdy_log[1].core != 1) begin
         n_fail++;
         $display("FAIL abort_rr: first=%0d second=%0d, required 0 then 1",
                  (rdy_log.size() > 0) ? rdy_log[0].core : -1,
                  (rdy_log.size() > 1) ? rdy_log[1].core : -1);
      end
   endtask

   initial begin
      rst      = 1'b1;
      MEMREAD  = '0;
      MEMWR    = '0;
      DMADDR   = '0;
      DOUT     = '0;
      INITWR   = 1'b0;
      INITADDR = '0;
      INITDATA = '0;
      for (int i = 0; i < DEPTH; i++) ram_model[i] = '0;
      test_reset();
      test_preload_read();
      test_write_then_read();
      test_read_write_both();
      test_round_robin();
      test_init_wrap();
      test_init_while_busy();
      test_all_cores();
      test_addr_wrap();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
